exe_redirect_ctrl: RTL and testbench
====================================

EXE_REDIRECT_CTRL -- requirements
Module: exe_redirect_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, meaning the number of younger pipeline stages squashed after a redirect (legal range 0..7).
REQ-002 SHALL have port clock, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port is_exe_stage, input, 1, execute-stage instruction valid this cycle.
REQ-005 SHALL have port take_jump, input, 1, the execute instruction redirects control flow (taken branch, jal or jalr).
REQ-006 SHALL have port target_addr, input, word (32), the redirect target computed by execute.
REQ-007 SHALL have port fetch_ready, input, 1, fetch accepts a redirect this cycle.
REQ-008 SHALL have port redirect_valid, output, 1, a redirect is offered to fetch.
REQ-009 SHALL have port redirect_addr, output, word (32), the offered target; stable while redirect_valid=1.
REQ-010 SHALL have port flush, output, 1, squash younger stages.
REQ-011 SHALL have port misalign_err, output, 1, one-cycle pulse for a target with bits[1:0]!=0.

Function
REQ-012 SHALL implement FSM states RUN, REDIRECT and FLUSH.
REQ-013 SHALL, in RUN with is_exe_stage=1, take_jump=1 and target_addr[1:0]=0, register target_addr and enter REDIRECT on the next edge.
REQ-014 SHALL, in RUN with is_exe_stage=1, take_jump=1 and target_addr[1:0]!=0, pulse misalign_err for exactly the next cycle and remain in RUN with no redirect.
REQ-015 SHALL drive redirect_valid=1 and flush=1 throughout REDIRECT; redirect_addr SHALL hold the registered target.
REQ-016 SHALL treat redirect_valid=1 and fetch_ready=1 in the same cycle as transfer; on transfer the FSM SHALL enter FLUSH with the counter loaded to FLUSH_DEPTH, or enter RUN when FLUSH_DEPTH=0.
REQ-017 SHALL hold REDIRECT indefinitely while fetch_ready=0.
REQ-018 SHALL drive flush=1 in FLUSH, decrement the counter each cycle, and enter RUN on the edge where the counter equals 1; flush SHALL therefore be high for exactly FLUSH_DEPTH cycles after the transfer cycle.
REQ-019 SHALL ignore is_exe_stage and take_jump in REDIRECT and FLUSH, because those instructions are wrong-path; the first eligible cycle is the first cycle in RUN.
REQ-020 SHALL give a redirect latency of 1 cycle, from the sampled take to redirect_valid=1.
REQ-021 SHALL keep redirect_valid=0 and flush=0 in RUN.

Reset
REQ-022 SHALL, while reset=0, force state RUN, counter 0, redirect_valid=0, redirect_addr=0, flush=0 and misalign_err=0, regardless of clock.
REQ-023 SHALL, when reset is asserted mid-REDIRECT or mid-FLUSH, abandon the operation and SHALL NOT complete the redirect after reset is released.

Configuration
REQ-024 SHALL, with macro EXE_REDIRECT_STATS_EN defined, add outputs taken_count and misalign_count (32 bits each, reset to 0, saturating at 0xFFFFFFFF), counting accepted takes and misalign_err pulses respectively.
REQ-025 SHALL, without EXE_REDIRECT_STATS_EN, have neither these ports nor their counters, with otherwise identical behaviour.

Structure
REQ-026 SHALL take the word typedef and the FSM state enum (RUN/REDIRECT/FLUSH) from the shared common definitions package.
REQ-027 SHALL implement the flush down-counter as sub-module flush_counter, with load, decrement and a last-cycle indication.

Verification
REQ-028 SHALL test: take with target 0x0000_0100 and fetch_ready=1 -> redirect_valid high 1 cycle with addr 0x100, then flush high 2 more cycles, then back to RUN.
REQ-029 SHALL test: take with fetch_ready=0 for 5 cycles -> redirect_valid and addr 0x100 stable for 5 cycles, transfer on cycle 6.
REQ-030 SHALL test: take with target 0x0000_0102 -> misalign_err one cycle, redirect_valid never asserted.
REQ-031 SHALL test: a second take during FLUSH (target 0x200) -> ignored; a take on the first RUN cycle -> accepted.
REQ-032 SHALL test: reset=0 during REDIRECT -> all outputs 0 immediately; after release, no redirect occurs.
REQ-033 SHALL test: FLUSH_DEPTH=0 build -> RUN follows the transfer cycle; with EXE_REDIRECT_STATS_EN, 3 takes and 1 misalign -> taken_count=3, misalign_count=1.

Source files
------------

// File: rtl/exe_redirect_ctrl_pkg.sv
// Shared definitions for the execute-stage redirect controller: data word, FSM states, counter width.
// Latency: n/a; backpressure: n/a.
package exe_redirect_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Wide enough for the largest legal squash depth (7).
    localparam int CNT_W = 3;

endpackage

// File: rtl/exe_redirect_ctrl_flush_counter.sv
// Squash down-counter: load a depth, decrement once per cycle, flag the final count.
// Latency: load/decrement visible next cycle; backpressure: none.
module flush_counter
    import exe_redirect_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == W'(1));

endmodule

// File: rtl/exe_redirect_ctrl.sv
// Turns an execute-stage taken jump into a fetch redirect followed by a squash of FLUSH_DEPTH younger stages.
// Latency: 1 cycle take->redirect_valid; holds the redirect while fetch_ready=0. Optional macro: EXE_REDIRECT_STATS_EN.
module exe_redirect_ctrl
    import exe_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  is_exe_stage,
    input  logic  take_jump,
    input  word_t target_addr,
    input  logic  fetch_ready,
    output logic  redirect_valid,
    output word_t redirect_addr,
    output logic  flush,
    output logic  misalign_err
`ifdef EXE_REDIRECT_STATS_EN
    ,
    output word_t taken_count,
    output word_t misalign_count
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_LD  = CNT_W'(FLUSH_DEPTH);
    localparam bit               HAS_FLUSH = (FLUSH_DEPTH != 0);

    state_t r_state;
    state_t w_next;
    word_t  r_target;
    logic   r_misalign;
    logic   w_take;
    logic   w_take_ok;
    logic   w_take_bad;
    logic   w_load;
    logic   w_dec;
    logic   w_last;

    // Takes are only honoured in RUN; anything seen in REDIRECT/FLUSH is wrong-path.
    assign w_take     = (r_state == RUN) && is_exe_stage && take_jump;
    assign w_take_ok  = w_take && (target_addr[1:0] == 2'b00);
    assign w_take_bad = w_take && (target_addr[1:0] != 2'b00);
    assign w_load     = HAS_FLUSH && (r_state == REDIRECT) && fetch_ready;
    assign w_dec      = (r_state == FLUSH);

    flush_counter #(
        .W(CNT_W)
    ) u_flush_counter (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (DEPTH_LD),
        .i_dec      (w_dec),
        .o_last     (w_last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_target   <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_misalign <= w_take_bad;
            if (w_take_ok) begin
                r_target <= target_addr;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        flush          = 1'b0;
        misalign_err   = r_misalign;
        case (r_state)
            RUN: begin
                if (w_take_ok) begin
                    w_next = REDIRECT;
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_addr  = r_target;
                flush          = 1'b1;
                if (fetch_ready) begin
                    w_next = HAS_FLUSH ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (w_last) begin
                    w_next = RUN;
                end
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

`ifdef EXE_REDIRECT_STATS_EN
    word_t r_taken_cnt;
    word_t r_misalign_cnt;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_taken_cnt    <= '0;
            r_misalign_cnt <= '0;
        end else begin
            if (w_take_ok && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (r_misalign && (r_misalign_cnt != '1)) begin
                r_misalign_cnt <= r_misalign_cnt + 1'b1;
            end
        end
    end

    assign taken_count    = r_taken_cnt;
    assign misalign_count = r_misalign_cnt;
`endif

endmodule

// File: tb/tb_exe_redirect_ctrl.sv
// Directed bench for exe_redirect_ctrl: vector table for the main flows, hand sequences for reset and depth-0.
// Covers the EXE_REDIRECT_STATS_EN counters when that macro is defined.
module tb_exe_redirect_ctrl;

    logic        clock;
    logic        reset;
    logic        is_exe_stage;
    logic        take_jump;
    logic [31:0] target_addr;
    logic        fetch_ready;

    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        flush;
    logic        misalign_err;

    logic        z_redirect_valid;
    logic [31:0] z_redirect_addr;
    logic        z_flush;
    logic        z_misalign_err;

`ifdef EXE_REDIRECT_STATS_EN
    logic [31:0] taken_count;
    logic [31:0] misalign_count;
    logic [31:0] z_taken_count;
    logic [31:0] z_misalign_count;
`endif

    int errors = 0;
    int checks = 0;

    exe_redirect_ctrl #(.FLUSH_DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .is_exe_stage   (is_exe_stage),
        .take_jump      (take_jump),
        .target_addr    (target_addr),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .flush          (flush),
        .misalign_err   (misalign_err)
`ifdef EXE_REDIRECT_STATS_EN
        ,
        .taken_count    (taken_count),
        .misalign_count (misalign_count)
`endif
    );

    exe_redirect_ctrl #(.FLUSH_DEPTH(0)) dut_d0 (
        .clock          (clock),
        .reset          (reset),
        .is_exe_stage   (is_exe_stage),
        .take_jump      (take_jump),
        .target_addr    (target_addr),
        .fetch_ready    (fetch_ready),
        .redirect_valid (z_redirect_valid),
        .redirect_addr  (z_redirect_addr),
        .flush          (z_flush),
        .misalign_err   (z_misalign_err)
`ifdef EXE_REDIRECT_STATS_EN
        ,
        .taken_count    (z_taken_count),
        .misalign_count (z_misalign_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        ej;
        logic        tj;
        logic [31:0] addr;
        logic        fr;
        logic        v;
        logic [31:0] a;
        logic        f;
        logic        m;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(logic ej, logic tj, logic [31:0] addr, logic fr,
                                logic v, logic [31:0] a, logic f, logic m);
        vec_t r;
        r.ej = ej; r.tj = tj; r.addr = addr; r.fr = fr;
        r.v = v; r.a = a; r.f = f; r.m = m;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic ej, input logic tj, input logic [31:0] addr, input logic fr);
        @(negedge clock);
        is_exe_stage = ej;
        take_jump    = tj;
        target_addr  = addr;
        fetch_ready  = fr;
        #1;
    endtask

    task automatic chk_main(input string tag, input logic v, input logic [31:0] a,
                            input logic f, input logic m);
        chk({tag, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, v});
        chk({tag, ".redirect_addr"},  redirect_addr,           a);
        chk({tag, ".flush"},          {31'b0, flush},          {31'b0, f});
        chk({tag, ".misalign_err"},   {31'b0, misalign_err},   {31'b0, m});
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 32'h100, 1,  0, 32'h0,   0, 0);
        vecs[1]  = mk(0, 0, 32'h0,   1,  1, 32'h100, 1, 0);
        vecs[2]  = mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 0);
        vecs[3]  = mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 0);
        vecs[4]  = mk(1, 1, 32'h100, 0,  0, 32'h0,   0, 0);
        for (int i = 5; i <= 9; i++) vecs[i] = mk(0, 0, 32'h0, 0, 1, 32'h100, 1, 0);
        vecs[10] = mk(0, 0, 32'h0,   1,  1, 32'h100, 1, 0);
        vecs[11] = mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 0);
        vecs[12] = mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 0);
        vecs[13] = mk(1, 1, 32'h102, 1,  0, 32'h0,   0, 0);
        vecs[14] = mk(0, 0, 32'h0,   1,  0, 32'h0,   0, 1);
        vecs[15] = mk(0, 0, 32'h0,   1,  0, 32'h0,   0, 0);
        vecs[16] = mk(1, 1, 32'h100, 1,  0, 32'h0,   0, 0);
        vecs[17] = mk(0, 0, 32'h0,   1,  1, 32'h100, 1, 0);
        vecs[18] = mk(1, 1, 32'h200, 1,  0, 32'h0,   1, 0);
        vecs[19] = mk(1, 1, 32'h200, 1,  0, 32'h0,   1, 0);
        vecs[20] = mk(1, 1, 32'h300, 0,  0, 32'h0,   0, 0);
        vecs[21] = mk(0, 0, 32'h0,   1,  1, 32'h300, 1, 0);
        vecs[22] = mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 0);
        vecs[23] = mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 0);
        vecs[24] = mk(0, 0, 32'h0,   0,  0, 32'h0,   0, 0);

        reset        = 1'b0;
        is_exe_stage = 1'b0;
        take_jump    = 1'b0;
        target_addr  = 32'h0;
        fetch_ready  = 1'b0;
        #2;
        chk_main("reset_state", 0, 32'h0, 0, 0);
`ifdef EXE_REDIRECT_STATS_EN
        chk("reset_taken_count",    taken_count,    32'h0);
        chk("reset_misalign_count", misalign_count, 32'h0);
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].ej, vecs[i].tj, vecs[i].addr, vecs[i].fr);
            chk_main($sformatf("vec%0d", i), vecs[i].v, vecs[i].a, vecs[i].f, vecs[i].m);
        end

        // Reset asserted mid-REDIRECT: outputs clear at once and the redirect never resumes.
        drive(1, 1, 32'h100, 0);
        drive(0, 0, 32'h0, 0);
        chk_main("pre_reset_redirect", 1, 32'h100, 1, 0);
        reset = 1'b0;
        #1;
        chk_main("reset_mid_redirect", 0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 1);
        drive(0, 0, 32'h0, 1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 1);
            chk_main($sformatf("post_reset%0d", i), 0, 32'h0, 0, 0);
        end

        // FLUSH_DEPTH=0 instance: back in RUN straight after the transfer cycle.
        drive(1, 1, 32'h100, 1);
        chk("d0_run.redirect_valid", {31'b0, z_redirect_valid}, 32'h0);
        drive(0, 0, 32'h0, 1);
        chk("d0_xfer.redirect_valid", {31'b0, z_redirect_valid}, 32'h1);
        chk("d0_xfer.redirect_addr",  z_redirect_addr,           32'h100);
        chk("d0_xfer.flush",          {31'b0, z_flush},          32'h1);
        drive(0, 0, 32'h0, 1);
        chk("d0_after.redirect_valid", {31'b0, z_redirect_valid}, 32'h0);
        chk("d0_after.flush",          {31'b0, z_flush},          32'h0);
        chk("d2_after.flush",          {31'b0, flush},            32'h1);
        drive(0, 0, 32'h0, 1);
        drive(0, 0, 32'h0, 1);
        chk("d2_done.flush",           {31'b0, flush},            32'h0);

`ifdef EXE_REDIRECT_STATS_EN
        // Fresh reset, then three accepted takes and one misaligned one.
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("stats_clear_taken", taken_count, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'h400 + 32'(k * 4), 1);
            repeat (4) drive(0, 0, 32'h0, 1);
        end
        drive(1, 1, 32'h401, 1);
        drive(0, 0, 32'h0, 1);
        drive(0, 0, 32'h0, 1);
        chk("stats_taken_count",    taken_count,    32'd3);
        chk("stats_misalign_count", misalign_count, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
